// File: rtl/bk_adder_pipe.sv
`timescale 1ns/1ps
// bk_adder_pipe: three-stage pipelined Brent-Kung adder/subtractor with a
// valid/ready stream interface and full backpressure.
//   S1: operand conditioning (B inverted for subtract), bit P/G, group P/G.
//   S2: up-sweep of the Brent-Kung prefix tree over the group pairs.
//   S3: down-sweep, group carries, per-group ripple sum, result flags.
// The carry-in is kept beside the tree rather than folded into group 0.
// Every group carry is therefore Gpre | (Ppre & c0), and every prefix P is
// consumed downstream.
// Optional feature macro: BK_ADDER_OVF_EN adds the registered signed-overflow
// output 'ovf'. When it is undefined, the port and its logic are absent.
module bk_adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int GROUPSIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef BK_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             zero
);

  localparam int NG   = WIDTH / GROUPSIZE;
  localparam int LOGN = $clog2(NG);

  // stage load enables and valid bits
  logic             s1_ld, s2_ld, s3_ld;
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

  // S1 combinational operand conditioning
  logic [WIDTH-1:0] s1_bx, s1_p, s1_g;
  logic             s1_c0;
  logic [NG-1:0]    s1_gg, s1_gp;

  // S1 registers
  logic [WIDTH-1:0] p1_q, p1_d, g1_q, g1_d;
  logic [NG-1:0]    gg1_q, gg1_d, gp1_q, gp1_d;
  logic             c01_q, c01_d;

  // S2 up-sweep and registers
  logic [NG-1:0]    up_g, up_p;
  logic [WIDTH-1:0] p2_q, p2_d, g2_q, g2_d;
  logic [NG-1:0]    gg2_q, gg2_d, gp2_q, gp2_d;
  logic             c02_q, c02_d;

  // S3 down-sweep, sum formation and output registers
  logic [NG-1:0]    dn_g, dn_p, grp_cin;
  logic             rip_c;
  logic [WIDTH-1:0] s3_sum;
  logic             s3_cout, s3_zero;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, zero_q, zero_d;
`ifdef BK_ADDER_OVF_EN
  logic             s3_ovf, ovf_q, ovf_d;
`endif

  // Load enables ripple back from the consumer. in_valid never reaches in_ready.
  assign s3_ld     = ~v3_q | out_ready;
  assign s2_ld     = ~v2_q | s3_ld;
  assign s1_ld     = ~v1_q | s2_ld;
  assign in_ready  = s1_ld;
  assign out_valid = v3_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
`ifdef BK_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

  // Stage valid bits: each takes its upstream valid on load and holds otherwise.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (s1_ld) begin
      v1_d = in_valid;
    end else begin
      v1_d = v1_q;
    end
    if (s2_ld) begin
      v2_d = v1_q;
    end else begin
      v2_d = v2_q;
    end
    if (s3_ld) begin
      v3_d = v2_q;
    end else begin
      v3_d = v3_q;
    end
  end

  // S1 operand conditioning: invert B for subtract, bit P/G, and group P/G by ripple.
  always_comb begin
    s1_bx = b ^ {WIDTH{sub}};
    s1_c0 = sub | cin;
    s1_p  = a ^ s1_bx;
    s1_g  = a & s1_bx;
    s1_gg = {NG{1'b0}};
    s1_gp = {NG{1'b1}};
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k < GROUPSIZE; k++) begin
        s1_gg[j] = s1_g[j*GROUPSIZE + k] | (s1_p[j*GROUPSIZE + k] & s1_gg[j]);
        s1_gp[j] = s1_gp[j] & s1_p[j*GROUPSIZE + k];
      end
    end
  end

  // S1 next state: capture a new beat on transfer, otherwise hold.
  always_comb begin
    p1_d  = p1_q;
    g1_d  = g1_q;
    gg1_d = gg1_q;
    gp1_d = gp1_q;
    c01_d = c01_q;
    if (s1_ld && in_valid) begin
      p1_d  = s1_p;
      g1_d  = s1_g;
      gg1_d = s1_gg;
      gp1_d = s1_gp;
      c01_d = s1_c0;
    end else begin
      p1_d  = p1_q;
      g1_d  = g1_q;
      gg1_d = gg1_q;
      gp1_d = gp1_q;
      c01_d = c01_q;
    end
  end

  // S2 up-sweep: at distance d, node m*2d+2d-1 absorbs node m*2d+d-1.
  always_comb begin
    int hi;
    int lo;
    hi   = 0;
    lo   = 0;
    up_g = gg1_q;
    up_p = gp1_q;
    for (int l = 0; l < LOGN; l++) begin
      for (int m = 0; m < NG / (2 << l); m++) begin
        hi       = m * (2 << l) + (2 << l) - 1;
        lo       = m * (2 << l) + (1 << l) - 1;
        up_g[hi] = up_g[hi] | (up_p[hi] & up_g[lo]);
        up_p[hi] = up_p[hi] & up_p[lo];
      end
    end
  end

  // S2 next state: load the up-sweep result when S2 advances, otherwise hold.
  always_comb begin
    p2_d  = p2_q;
    g2_d  = g2_q;
    gg2_d = gg2_q;
    gp2_d = gp2_q;
    c02_d = c02_q;
    if (s2_ld && v1_q) begin
      p2_d  = p1_q;
      g2_d  = g1_q;
      gg2_d = up_g;
      gp2_d = up_p;
      c02_d = c01_q;
    end else begin
      p2_d  = p2_q;
      g2_d  = g2_q;
      gg2_d = gg2_q;
      gp2_d = gp2_q;
      c02_d = c02_q;
    end
  end

  // S3 down-sweep fills the remaining prefixes; group carries then drive a per-group ripple sum.
  always_comb begin
    int hi;
    int lo;
    hi     = 0;
    lo     = 0;
    dn_g   = gg2_q;
    dn_p   = gp2_q;
    for (int l = LOGN - 2; l >= 0; l--) begin
      for (int m = 1; m < NG / (2 << l); m++) begin
        hi       = m * (2 << l) + (1 << l) - 1;
        lo       = m * (2 << l) - 1;
        dn_g[hi] = dn_g[hi] | (dn_p[hi] & dn_g[lo]);
        dn_p[hi] = dn_p[hi] & dn_p[lo];
      end
    end
    grp_cin = {dn_g[NG-2:0] | (dn_p[NG-2:0] & {(NG-1){c02_q}}), c02_q};
    s3_cout = dn_g[NG-1] | (dn_p[NG-1] & c02_q);
    s3_sum  = {WIDTH{1'b0}};
    rip_c   = 1'b0;
    for (int j = 0; j < NG; j++) begin
      rip_c = grp_cin[j];
      for (int k = 0; k < GROUPSIZE; k++) begin
        s3_sum[j*GROUPSIZE + k] = p2_q[j*GROUPSIZE + k] ^ rip_c;
        rip_c = g2_q[j*GROUPSIZE + k] | (p2_q[j*GROUPSIZE + k] & rip_c);
      end
    end
    s3_zero = (s3_sum == {WIDTH{1'b0}});
  end

`ifdef BK_ADDER_OVF_EN
  // Signed overflow: operands agree in sign (MSB P is 0, so MSB G is that sign) and the sum differs.
  always_comb begin
    s3_ovf = ~p2_q[WIDTH-1] & (s3_sum[WIDTH-1] ^ g2_q[WIDTH-1]);
  end
`endif

  // S3 next state: output data changes only when a real beat loads into S3.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    zero_d = zero_q;
`ifdef BK_ADDER_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (s3_ld && v2_q) begin
      sum_d  = s3_sum;
      cout_d = s3_cout;
      zero_d = s3_zero;
`ifdef BK_ADDER_OVF_EN
      ovf_d  = s3_ovf;
`endif
    end else begin
      sum_d  = sum_q;
      cout_d = cout_q;
      zero_d = zero_q;
`ifdef BK_ADDER_OVF_EN
      ovf_d  = ovf_q;
`endif
    end
  end

  // Valid bits: cleared asynchronously, so in-flight beats are discarded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  // S1 and S2 pipeline data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_q  <= {WIDTH{1'b0}};
      g1_q  <= {WIDTH{1'b0}};
      gg1_q <= {NG{1'b0}};
      gp1_q <= {NG{1'b0}};
      c01_q <= 1'b0;
      p2_q  <= {WIDTH{1'b0}};
      g2_q  <= {WIDTH{1'b0}};
      gg2_q <= {NG{1'b0}};
      gp2_q <= {NG{1'b0}};
      c02_q <= 1'b0;
    end else begin
      p1_q  <= p1_d;
      g1_q  <= g1_d;
      gg1_q <= gg1_d;
      gp1_q <= gp1_d;
      c01_q <= c01_d;
      p2_q  <= p2_d;
      g2_q  <= g2_d;
      gg2_q <= gg2_d;
      gp2_q <= gp2_d;
      c02_q <= c02_d;
    end
  end

  // S3 result registers driving the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= {WIDTH{1'b0}};
      cout_q <= 1'b0;
      zero_q <= 1'b0;
`ifdef BK_ADDER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      zero_q <= zero_d;
`ifdef BK_ADDER_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_bk_adder_pipe.sv
`timescale 1ns/1ps
// Testbench for bk_adder_pipe. A 32-bit instance is exercised with directed
// cases, a random stream, backpressure and reset. 64/8 and 16/2 instances get
// carry-chain patterns. Expected results come from plain integer arithmetic.
module tb_bk_adder_pipe;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        z;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, zero;
  logic [31:0] a, b, sum;
  logic        in_valid64, in_ready64, cin64, sub64, out_valid64, out_ready64, cout64, zero64;
  logic [63:0] a64, b64, sum64;
  logic        in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16, cout16, zero16;
  logic [15:0] a16, b16, sum16;
`ifdef BK_ADDER_OVF_EN
  logic        ovf, ovf64, ovf16;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  logic        s_in_ready, s_out_valid;
  exp_t        sb[$];
  logic [64:0] r65;
  logic [16:0] r17;

  bk_adder_pipe #(.WIDTH(32), .GROUPSIZE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout),
`ifdef BK_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .zero(zero)
  );

  bk_adder_pipe #(.WIDTH(64), .GROUPSIZE(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .cin(cin64), .sub(sub64), .out_valid(out_valid64),
    .out_ready(out_ready64), .sum(sum64), .cout(cout64),
`ifdef BK_ADDER_OVF_EN
    .ovf(ovf64),
`endif
    .zero(zero64)
  );

  bk_adder_pipe #(.WIDTH(16), .GROUPSIZE(2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16),
`ifdef BK_ADDER_OVF_EN
    .ovf(ovf16),
`endif
    .zero(zero16)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    chk(tag, {79'd0, obs}, {79'd0, expv});
  endtask

  task automatic chki(input string tag, input int obs, input int expv);
    chk(tag, {48'd0, 32'(obs)}, {48'd0, 32'(expv)});
  endtask

  // Reference: plain integer add/subtract, signed range check for overflow.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mcin, input logic msub);
    exp_t        m;
    logic [32:0] r;
    longint      sr;
    if (msub) begin
      m.s = ma - mb;
      m.c = (ma >= mb);
      sr  = longint'($signed(ma)) - longint'($signed(mb));
    end else begin
      r   = {1'b0, ma} + {1'b0, mb} + {32'd0, mcin};
      m.s = r[31:0];
      m.c = r[32];
      sr  = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mcin);
    end
    m.z = (m.s == 32'd0);
    m.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return m;
  endfunction

  // One cycle: sample handshakes at negedge, score retires, record accepts.
  task automatic step();
    exp_t e;
    logic acc, ret;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    acc = in_valid && in_ready;
    ret = out_valid && out_ready;
    if (ret) begin
      chk1("sb_nonempty", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", {46'd0, cout, zero, sum}, {46'd0, e.c, e.z, e.s});
`ifdef BK_ADDER_OVF_EN
        chk1("result_ovf", ovf, e.o);
`endif
      end
    end
    if (acc) begin
      n_acc++;
      sb.push_back(model(a, b, cin, sub));
    end
    @(posedge clk);
    #1;
  endtask

  // Single beat with latency measurement and fixed expected values.
  task automatic directed(input string tag, input logic [31:0] da, input logic [31:0] db,
                          input logic dcin, input logic dsub, input logic [31:0] esum,
                          input logic ecout, input logic ezero, input logic eovf);
    int lat;
    a = da; b = db; cin = dcin; sub = dsub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid) lat = k;
      if (lat == 0) begin
        @(posedge clk);
        #1;
      end
    end
    chki({tag, "_latency"}, lat, 3);
    chk({tag, "_result"}, {46'd0, cout, zero, sum}, {46'd0, ecout, ezero, esum});
`ifdef BK_ADDER_OVF_EN
    chk1({tag, "_ovf"}, ovf, eovf);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid64 = 1'b0; a64 = 64'd0; b64 = 64'd0; cin64 = 1'b0; sub64 = 1'b0; out_ready64 = 1'b1;
    in_valid16 = 1'b0; a16 = 16'd0; b16 = 16'd0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b1;
    s_in_ready = 1'b0; s_out_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs", {46'd0, cout, zero, sum}, 80'd0);
`ifdef BK_ADDER_OVF_EN
    chk1("rst_ovf", ovf, 1'b0);
`endif
    chk1("rst_out_valid64", out_valid64, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_in_ready", in_ready, 1'b1);
    chk1("post_rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Directed cases
    directed("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    directed("sub5_7",  32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    directed("sub_cin", 32'd10,        32'd3,         1'b0, 1'b1, 32'd7,         1'b1, 1'b0, 1'b0);
    directed("add_cin", 32'd1,         32'd2,         1'b1, 1'b0, 32'd4,         1'b0, 1'b0, 1'b0);
    directed("add_ovf", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);

    // Back-to-back random stream
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      if (i % 10 == 0) a = 32'hFFFF_FFFF;
      if (i % 10 == 5) b = a;
      step();
      chk1("stream_in_ready", s_in_ready, 1'b1);
      if (i >= 3) chk1("stream_out_valid", s_out_valid, 1'b1);
    end
    in_valid = 1'b0;
    repeat (5) step();
    chki("stream_drained", sb.size(), 0);

    // Backpressure: fill and hold
    out_ready = 1'b0;
    in_valid  = 1'b1;
    n_acc     = 0;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      step();
      if (i >= 3) begin
        chk1("full_in_ready", s_in_ready, 1'b0);
        chk1("full_out_valid", s_out_valid, 1'b1);
        chk("stall_hold", {46'd0, cout, zero, sum}, {46'd0, sb[0].c, sb[0].z, sb[0].s});
      end
    end
    chki("full_accept_count", n_acc, 3);
    out_ready = 1'b1;
    a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b0;
    step();
    chk1("release_in_ready", s_in_ready, 1'b1);
    in_valid = 1'b0;
    repeat (6) step();
    chki("release_drained", sb.size(), 0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
    step();
    a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk1("pre_reset_out_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("reset_out_valid", out_valid, 1'b0);
    chk("reset_outputs", {46'd0, cout, zero, sum}, 80'd0);
    sb.delete();
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk1("no_stale_out_valid", s_out_valid, 1'b0);
      chk1("reset_in_ready", s_in_ready, 1'b1);
    end

    // Carry chain, WIDTH=64 GROUPSIZE=8
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < 2; c++) begin
        a64 = {64{1'b1}};
        b64 = 64'd1 << (j * 8);
        cin64 = (c != 0);
        in_valid64 = 1'b1;
        r65 = {1'b0, a64} + {1'b0, b64} + {64'd0, cin64};
        @(negedge clk);
        chk1("c64_in_ready", in_ready64, 1'b1);
        @(posedge clk);
        #1;
        in_valid64 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk1("c64_out_valid", out_valid64, 1'b1);
        chk("c64_result", {14'd0, cout64, zero64, sum64}, {14'd0, r65[64], (r65[63:0] == 64'd0), r65[63:0]});
`ifdef BK_ADDER_OVF_EN
        chk1("c64_ovf", ovf64, 1'b0);
`endif
        @(posedge clk);
        #1;
      end
    end

    // Carry chain, WIDTH=16 GROUPSIZE=2
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < 2; c++) begin
        a16 = {16{1'b1}};
        b16 = 16'd1 << (j * 2);
        cin16 = (c != 0);
        in_valid16 = 1'b1;
        r17 = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
        @(negedge clk);
        chk1("c16_in_ready", in_ready16, 1'b1);
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk1("c16_out_valid", out_valid16, 1'b1);
        chk("c16_result", {62'd0, cout16, zero16, sum16}, {62'd0, r17[16], (r17[15:0] == 16'd0), r17[15:0]});
`ifdef BK_ADDER_OVF_EN
        chk1("c16_ovf", ovf16, 1'b0);
`endif
        @(posedge clk);
        #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
